// File: rtl/regfile_sequencer.sv
// regfile_sequencer: expands one transfer command into a registered two-cycle
// strobe sequence (SETUP: bus source drive, XFER: source held plus sink load)
// for a bank of NREG gpreg registers. All strobes are active-low and registered.
module regfile_sequencer #(
  parameter int NREG = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CMD_valid,
  output logic            CMD_ready,
  input  logic [1:0]      CMD_op,
  input  logic [2:0]      CMD_src,
  input  logic [2:0]      CMD_rhs,
  input  logic [2:0]      CMD_dst,
  input  logic [7:0]      CMD_imm,
  output logic [NREG-1:0] LOAD_bar,
  output logic [NREG-1:0] ASSERT_bar,
  output logic [NREG-1:0] ASSERT_LHS_bar,
  output logic [NREG-1:0] ASSERT_RHS_bar,
  output logic            ALU_ASSERT_bar,
  output logic            IMM_ASSERT_bar,
  output logic [7:0]      IMM_out,
  output logic            EXT_LOAD_bar,
  output logic            BUSY,
  output logic            ERR,
  output logic [7:0]      XFER_COUNT
);

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_ALU = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [1:0] OP_OUT = 2'b11;

  typedef enum logic [1:0] {IDLE, SETUP, XFER} state_t;

  // Source drives are registered at accept and simply held through XFER,
  // so only the fields that pick the sink have to be remembered.
  typedef struct packed {
    logic [1:0] op;
    logic [2:0] dst;
  } sink_t;

  state_t state;
  sink_t  sink;
  logic   cmd_ok;

  // Active-low one-hot select of register idx.
  function automatic logic [NREG-1:0] sel_n(input logic [2:0] idx);
    logic [7:0] oh;
    oh = 8'd1 << idx;
    return ~oh[NREG-1:0];
  endfunction

  function automatic logic in_rng(input logic [2:0] idx);
    return {29'd0, idx} < 32'(NREG);
  endfunction

  // Only the indices the op actually uses are range-checked.
  always_comb begin
    cmd_ok = 1'b0;
    case (CMD_op)
      OP_MOV:  cmd_ok = in_rng(CMD_src) && in_rng(CMD_dst);
      OP_ALU:  cmd_ok = in_rng(CMD_src) && in_rng(CMD_rhs) && in_rng(CMD_dst);
      OP_LDI:  cmd_ok = in_rng(CMD_dst);
      default: cmd_ok = in_rng(CMD_src);
    endcase
  end

  assign CMD_ready = (state == IDLE);
  assign BUSY      = (state != IDLE);

  // Sequencer FSM; every strobe is a flop so reset forces them high at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= IDLE;
      sink           <= '0;
      ERR            <= 1'b0;
      XFER_COUNT     <= 8'd0;
      IMM_out        <= 8'd0;
      LOAD_bar       <= '1;
      ASSERT_bar     <= '1;
      ASSERT_LHS_bar <= '1;
      ASSERT_RHS_bar <= '1;
      ALU_ASSERT_bar <= 1'b1;
      IMM_ASSERT_bar <= 1'b1;
      EXT_LOAD_bar   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (CMD_valid) begin
            if (cmd_ok) begin
              state    <= SETUP;
              sink.op  <= CMD_op;
              sink.dst <= CMD_dst;
              case (CMD_op)
                OP_MOV, OP_OUT: ASSERT_bar <= sel_n(CMD_src);
                OP_ALU: begin
                  ASSERT_LHS_bar <= sel_n(CMD_src);
                  ASSERT_RHS_bar <= sel_n(CMD_rhs);
                end
                default: begin
                  IMM_ASSERT_bar <= 1'b0;
                  IMM_out        <= CMD_imm;
                end
              endcase
            end else begin
              ERR <= 1'b1;
            end
          end
        end
        SETUP: begin
          state <= XFER;
          case (sink.op)
            OP_MOV, OP_LDI: LOAD_bar <= sel_n(sink.dst);
            OP_ALU: begin
              ALU_ASSERT_bar <= 1'b0;
              LOAD_bar       <= sel_n(sink.dst);
            end
            default: EXT_LOAD_bar <= 1'b0;
          endcase
        end
        default: begin
          state          <= IDLE;
          XFER_COUNT     <= XFER_COUNT + 8'd1;
          IMM_out        <= 8'd0;
          LOAD_bar       <= '1;
          ASSERT_bar     <= '1;
          ASSERT_LHS_bar <= '1;
          ASSERT_RHS_bar <= '1;
          ALU_ASSERT_bar <= 1'b1;
          IMM_ASSERT_bar <= 1'b1;
          EXT_LOAD_bar   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: a per-cycle expected-output queue model plus
// directed literal checks, randomized command traffic, mid-XFER reset and
// a 256-command counter wrap.
module tb_regfile_sequencer;
  localparam int N = 4;

  logic         CLK, RST, CMD_valid, CMD_ready;
  logic [1:0]   CMD_op;
  logic [2:0]   CMD_src, CMD_rhs, CMD_dst;
  logic [7:0]   CMD_imm;
  logic [N-1:0] LOAD_bar, ASSERT_bar, ASSERT_LHS_bar, ASSERT_RHS_bar;
  logic         ALU_ASSERT_bar, IMM_ASSERT_bar, EXT_LOAD_bar, BUSY, ERR;
  logic [7:0]   IMM_out, XFER_COUNT;

  regfile_sequencer #(.NREG(N)) dut (
    .CLK(CLK), .RST(RST), .CMD_valid(CMD_valid), .CMD_ready(CMD_ready),
    .CMD_op(CMD_op), .CMD_src(CMD_src), .CMD_rhs(CMD_rhs), .CMD_dst(CMD_dst),
    .CMD_imm(CMD_imm), .LOAD_bar(LOAD_bar), .ASSERT_bar(ASSERT_bar),
    .ASSERT_LHS_bar(ASSERT_LHS_bar), .ASSERT_RHS_bar(ASSERT_RHS_bar),
    .ALU_ASSERT_bar(ALU_ASSERT_bar), .IMM_ASSERT_bar(IMM_ASSERT_bar),
    .IMM_out(IMM_out), .EXT_LOAD_bar(EXT_LOAD_bar), .BUSY(BUSY), .ERR(ERR),
    .XFER_COUNT(XFER_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected visible outputs for one cycle.
  typedef struct {
    logic [N-1:0] load, asrt, lhs, rhs;
    logic         alu, imm_a, ext, busy, ready;
    logic [7:0]   imm;
  } snap_t;

  function automatic snap_t idle_snap();
    snap_t s;
    s.load = '1; s.asrt = '1; s.lhs = '1; s.rhs = '1;
    s.alu = 1'b1; s.imm_a = 1'b1; s.ext = 1'b1;
    s.busy = 1'b0; s.ready = 1'b1; s.imm = 8'd0;
    return s;
  endfunction

  // What the bus looks like in the drive phase (xfer=0) or sink phase (xfer=1).
  function automatic snap_t phase_snap(input logic [1:0] op, input logic [2:0] src,
                                       input logic [2:0] rhs, input logic [2:0] dst,
                                       input logic [7:0] imm, input bit xfer);
    snap_t s;
    logic [N-1:0] one;
    one = 1;
    s = idle_snap();
    s.busy = 1'b1; s.ready = 1'b0;
    case (op)
      2'd0: begin s.asrt = ~(one << src); if (xfer) s.load = ~(one << dst); end
      2'd1: begin
        s.lhs = ~(one << src); s.rhs = ~(one << rhs);
        if (xfer) begin s.alu = 1'b0; s.load = ~(one << dst); end
      end
      2'd2: begin s.imm_a = 1'b0; s.imm = imm; if (xfer) s.load = ~(one << dst); end
      default: begin s.asrt = ~(one << src); if (xfer) s.ext = 1'b0; end
    endcase
    return s;
  endfunction

  function automatic bit legal(input logic [1:0] op, input logic [2:0] src,
                               input logic [2:0] rhs, input logic [2:0] dst);
    case (op)
      2'd0:    return (int'(src) < N) && (int'(dst) < N);
      2'd1:    return (int'(src) < N) && (int'(rhs) < N) && (int'(dst) < N);
      2'd2:    return int'(dst) < N;
      default: return int'(src) < N;
    endcase
  endfunction

  snap_t      q[$];
  logic [7:0] m_cnt = 8'd0;
  logic       m_err = 1'b0;

  // Reference model: a command turns into two queued cycles of outputs.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      q.delete(); m_cnt = 8'd0; m_err = 1'b0;
    end else if (q.size() != 0) begin
      if (q.size() == 1) m_cnt = m_cnt + 8'd1;
      void'(q.pop_front());
    end else if (CMD_valid) begin
      if (legal(CMD_op, CMD_src, CMD_rhs, CMD_dst)) begin
        q.push_back(phase_snap(CMD_op, CMD_src, CMD_rhs, CMD_dst, CMD_imm, 1'b0));
        q.push_back(phase_snap(CMD_op, CMD_src, CMD_rhs, CMD_dst, CMD_imm, 1'b1));
      end else begin
        m_err = 1'b1;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge CLK) begin
    if (!RST) begin
      snap_t e;
      int    drv;
      e = (q.size() != 0) ? q[0] : idle_snap();
      cmp("LOAD_bar", 32'(LOAD_bar), 32'(e.load));
      cmp("ASSERT_bar", 32'(ASSERT_bar), 32'(e.asrt));
      cmp("ASSERT_LHS_bar", 32'(ASSERT_LHS_bar), 32'(e.lhs));
      cmp("ASSERT_RHS_bar", 32'(ASSERT_RHS_bar), 32'(e.rhs));
      cmp("ALU_ASSERT_bar", 32'(ALU_ASSERT_bar), 32'(e.alu));
      cmp("IMM_ASSERT_bar", 32'(IMM_ASSERT_bar), 32'(e.imm_a));
      cmp("IMM_out", 32'(IMM_out), 32'(e.imm));
      cmp("EXT_LOAD_bar", 32'(EXT_LOAD_bar), 32'(e.ext));
      cmp("BUSY", 32'(BUSY), 32'(e.busy));
      cmp("CMD_ready", 32'(CMD_ready), 32'(e.ready));
      cmp("ERR", 32'(ERR), 32'(m_err));
      cmp("XFER_COUNT", 32'(XFER_COUNT), 32'(m_cnt));
      drv = $countones(~ASSERT_bar) + int'(!ALU_ASSERT_bar) + int'(!IMM_ASSERT_bar);
      cmp("bus_exclusion", 32'(drv <= 1), 32'd1);
      cmp("onehot_load", 32'($countones(~LOAD_bar) <= 1), 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // Present a command for one accept edge; returns at the SETUP-cycle negedge.
  task automatic send(input logic [1:0] op, input logic [2:0] src, input logic [2:0] rhs,
                      input logic [2:0] dst, input logic [7:0] imm);
    CMD_op = op; CMD_src = src; CMD_rhs = rhs; CMD_dst = dst; CMD_imm = imm;
    CMD_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    CMD_valid = 1'b0;
  endtask

  int ext_lows;

  initial begin
    RST = 1'b1; CMD_valid = 1'b0;
    CMD_op = 2'd0; CMD_src = 3'd0; CMD_rhs = 3'd0; CMD_dst = 3'd0; CMD_imm = 8'd0;
    repeat (2) @(negedge CLK);
    cmp("rst_ready", 32'(CMD_ready), 32'd1);
    cmp("rst_busy", 32'(BUSY), 32'd0);
    cmp("rst_err", 32'(ERR), 32'd0);
    cmp("rst_count", 32'(XFER_COUNT), 32'd0);
    cmp("rst_imm", 32'(IMM_out), 32'd0);
    cmp("rst_bars", {LOAD_bar, ASSERT_bar, ASSERT_LHS_bar, ASSERT_RHS_bar,
                     ALU_ASSERT_bar, IMM_ASSERT_bar, EXT_LOAD_bar}, 32'h7ffff);
    RST = 1'b0;
    @(negedge CLK);

    // MOV r1 -> r2
    send(2'd0, 3'd1, 3'd0, 3'd2, 8'd0);
    cmp("mov_setup_assert", 32'(ASSERT_bar), 32'hd);
    cmp("mov_setup_load", 32'(LOAD_bar), 32'hf);
    cmp("mov_setup_ready", 32'(CMD_ready), 32'd0);
    @(negedge CLK);
    cmp("mov_xfer_assert", 32'(ASSERT_bar), 32'hd);
    cmp("mov_xfer_load", 32'(LOAD_bar), 32'hb);
    cmp("mov_xfer_ready", 32'(CMD_ready), 32'd0);
    @(negedge CLK);
    cmp("mov_done_ready", 32'(CMD_ready), 32'd1);
    cmp("mov_done_count", 32'(XFER_COUNT), 32'd1);

    // ALU r0 op r3 -> r0
    send(2'd1, 3'd0, 3'd3, 3'd0, 8'd0);
    cmp("alu_setup_lhs", 32'(ASSERT_LHS_bar), 32'he);
    cmp("alu_setup_rhs", 32'(ASSERT_RHS_bar), 32'h7);
    cmp("alu_setup_alu", 32'(ALU_ASSERT_bar), 32'd1);
    @(negedge CLK);
    cmp("alu_xfer_alu", 32'(ALU_ASSERT_bar), 32'd0);
    cmp("alu_xfer_load", 32'(LOAD_bar), 32'he);
    cmp("alu_xfer_lhs", 32'(ASSERT_LHS_bar), 32'he);
    @(negedge CLK);

    // LDI 0xA5 -> r3 with valid held for three back-to-back commands
    CMD_op = 2'd2; CMD_dst = 3'd3; CMD_imm = 8'ha5; CMD_src = 3'd7; CMD_rhs = 3'd7;
    CMD_valid = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      cmp("ldi_imm", 32'(IMM_out), ((i - 1) % 3 < 2) ? 32'ha5 : 32'd0);
      cmp("ldi_ready", 32'(CMD_ready), ((i - 1) % 3 == 2) ? 32'd1 : 32'd0);
      if ((i - 1) % 3 == 1) cmp("ldi_load", 32'(LOAD_bar), 32'h7);
    end
    CMD_valid = 1'b0;
    cmp("ldi_count", 32'(XFER_COUNT), 32'd5);

    // Illegal MOV destination, then a normal MOV
    send(2'd0, 3'd0, 3'd0, 3'd5, 8'd0);
    cmp("bad_err", 32'(ERR), 32'd1);
    cmp("bad_busy", 32'(BUSY), 32'd0);
    cmp("bad_assert", 32'(ASSERT_bar), 32'hf);
    cmp("bad_count", 32'(XFER_COUNT), 32'd5);
    send(2'd0, 3'd3, 3'd0, 3'd0, 8'd0);
    cmp("after_bad_assert", 32'(ASSERT_bar), 32'h7);
    @(negedge CLK);
    cmp("after_bad_load", 32'(LOAD_bar), 32'he);
    @(negedge CLK);
    cmp("after_bad_count", 32'(XFER_COUNT), 32'd6);
    cmp("after_bad_err", 32'(ERR), 32'd1);

    // Randomized traffic, occasional out-of-range indices
    for (int i = 0; i < 400; i++) begin
      CMD_valid = ($urandom_range(0, 3) != 0);
      CMD_op    = 2'($urandom_range(0, 3));
      CMD_src   = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      CMD_rhs   = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      CMD_dst   = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      CMD_imm   = 8'($urandom);
      @(negedge CLK);
    end
    CMD_valid = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset pulsed in the middle of XFER
    send(2'd0, 3'd0, 3'd0, 3'd1, 8'd0);
    @(negedge CLK);
    cmp("pre_rst_load", 32'(LOAD_bar), 32'hd);
    #2 RST = 1'b1;
    #1;
    cmp("rst_mid_load", 32'(LOAD_bar), 32'hf);
    cmp("rst_mid_assert", 32'(ASSERT_bar), 32'hf);
    cmp("rst_mid_count", 32'(XFER_COUNT), 32'd0);
    cmp("rst_mid_err", 32'(ERR), 32'd0);
    #1 RST = 1'b0;
    @(negedge CLK);
    cmp("post_rst_load", 32'(LOAD_bar), 32'hf);
    cmp("post_rst_ready", 32'(CMD_ready), 32'd1);

    // 256 back-to-back OUT commands wrap the counter
    ext_lows = 0;
    CMD_op = 2'd3; CMD_src = 3'($urandom_range(0, 3)); CMD_valid = 1'b1;
    for (int i = 0; i < 768; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (!EXT_LOAD_bar) ext_lows++;
    end
    CMD_valid = 1'b0;
    cmp("out_ext_lows", 32'(ext_lows), 32'd256);
    cmp("out_wrap_count", 32'(XFER_COUNT), 32'd0);
    @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
